// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the selectable-channel skid mux.
//   buf_state_t : occupancy of the 2-entry skid buffer (EMPTY, ONE, FULL)
//   XFER_CNT_W  : width of the completed-output-transfer counter
package mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/skid_buf.sv
// skid_buf: 2-entry FIFO with valid/ready handshakes on both sides.
// in_ready comes from a register, so the upstream ready path is cut.
// An empty buffer plus an input transfer shows the beat on the next cycle.
// With out_ready held high, one beat per cycle passes through.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   in_valid / in_ready   : upstream handshake
//   in_payload            : beat captured on an input transfer
//   out_valid / out_ready : downstream handshake
//   out_payload           : oldest buffered beat, held while stalled
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload
);
    import mux_pkg::*;

    buf_state_t   state_reg, state_next;
    logic [W-1:0] head_reg;     // oldest beat, drives the output
    logic [W-1:0] tail_reg;     // second beat, only meaningful in FULL
    logic         in_ready_reg;
    logic         push, pop;

    assign push = in_valid && in_ready_reg;
    assign pop  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL:  if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        out_valid   = (state_reg != EMPTY);
        out_payload = head_reg;
        in_ready    = in_ready_reg;
    end

    // in_ready is computed one cycle early from the next state so that
    // it can be registered without ever admitting a third beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_reg <= 1'b1;
        end else begin
            in_ready_reg <= (state_next != FULL);
        end
    end

    // Datapath. A push into FULL cannot happen because in_ready is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            unique case (state_reg)
                EMPTY: if (push) head_reg <= in_payload;
                ONE: begin
                    // Simultaneous push/pop replaces the head directly.
                    if (push && pop) head_reg <= in_payload;
                    else if (push)   tail_reg <= in_payload;
                end
                FULL:  if (pop) head_reg <= tail_reg;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mux_nxw_skid.sv
// mux_nxw_skid: N-input, W-bit channel selector feeding a 2-entry skid
// buffer, with a count of completed output transfers.
// A select >= NUM_IN yields zero data and raises the err flag for that beat.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   in_valid / in_ready   : upstream handshake (in_ready registered)
//   in_data               : packed channels, channel k at [k*DATA_W +: DATA_W]
//   in_sel                : channel select for the offered beat
//   out_valid / out_ready : downstream handshake
//   out_data, out_sel     : selected data and the select that produced it
//   out_err               : beat was offered with an out-of-range select
//   xfer_cnt              : completed output transfers, wraps at 16 bits
module mux_nxw_skid
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_err,
    output logic [XFER_CNT_W-1:0]    xfer_cnt
);

    localparam int PAY_W = DATA_W + SEL_W + 1;

    logic [DATA_W-1:0]     ch [NUM_IN];
    logic [DATA_W-1:0]     sel_data;
    logic                  sel_err;
    logic [PAY_W-1:0]      in_payload, out_payload;
    logic [XFER_CNT_W-1:0] xfer_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_ch
            assign ch[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // One extra bit on the compare so NUM_IN itself is representable.
    always_comb begin
        sel_err  = ({1'b0, in_sel} >= (SEL_W+1)'(NUM_IN));
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) sel_data = ch[k];
        end
    end

    assign in_payload = {sel_err, in_sel, sel_data};

    skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload)
    );

    assign out_data = out_payload[DATA_W-1:0];
    assign out_sel  = out_payload[DATA_W +: SEL_W];
    assign out_err  = out_payload[PAY_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_reg <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
        end
    end

    assign xfer_cnt = xfer_cnt_reg;

endmodule

// File: tb/tb_mux_nxw_skid.sv
module tb_mux_nxw_skid;

    logic        clk = 1'b0;
    logic        rst;
    // default instance: NUM_IN=4, DATA_W=8
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0] in_data;
    logic [1:0]  in_sel, out_sel;
    logic [7:0]  out_data;
    logic [15:0] xfer_cnt;
    // NUM_IN=3 instance for the out-of-range select case
    logic        in_valid3, in_ready3, out_valid3, out_ready3, out_err3;
    logic [23:0] in_data3;
    logic [1:0]  in_sel3, out_sel3;
    logic [7:0]  out_data3;
    logic [15:0] xfer_cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_nxw_skid dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_err(out_err), .xfer_cnt(xfer_cnt)
    );

    mux_nxw_skid #(.NUM_IN(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_sel(in_sel3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .out_sel(out_sel3), .out_err(out_err3), .xfer_cnt(xfer_cnt3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (default instance) ----------------
    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
        logic       e;
    } beat_t;

    beat_t       mq[$];
    logic [15:0] mcnt;
    bit          live  = 0;
    bit          trace = 0;
    bit          m_pop, m_push;
    beat_t       m_b;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mcnt = '0;
            live = 1;
        end else if (live) begin
            m_pop  = (mq.size() > 0) && out_ready;
            m_push = in_valid && (mq.size() < 2);
            if (m_pop) begin
                if (trace)
                    $display("xfer %0d: data=%02h sel=%0d err=%0b", mcnt + 16'd1,
                             mq[0].d, mq[0].s, mq[0].e);
                void'(mq.pop_front());
                mcnt = mcnt + 16'd1;
            end
            if (m_push) begin
                m_b.d = in_data[int'(in_sel)*8 +: 8];
                m_b.s = in_sel;
                m_b.e = 1'b0;   // every 2-bit select is in range for 4 inputs
                mq.push_back(m_b);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (live) begin
            chk("out_valid", out_valid, mq.size() != 0);
            chk("in_ready", in_ready, mq.size() < 2);
            chk("xfer_cnt", xfer_cnt, mcnt);
            if (mq.size() != 0) begin
                chk("out_data", out_data, mq[0].d);
                chk("out_sel", out_sel, mq[0].s);
                chk("out_err", out_err, mq[0].e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_data = '0; in_sel = 0; out_ready = 0;
        in_valid3 = 0; in_data3 = '0; in_sel3 = 0; out_ready3 = 0;
        step(); step();
        rst = 1'b0;

        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_err", out_err, 0);

        // Test 1: select mapping, back-to-back
        trace = 1;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] lits;
            lits = 32'h44332211;
            in_valid = 1; in_sel = 2'(i);
            step();
            chk("t1_data", out_data, lits[i*8 +: 8]);
            chk("t1_valid", out_valid, 1);
        end
        in_valid = 0;
        step();
        chk("t1_cnt", xfer_cnt, 4);

        // Test 2: backpressure
        in_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        out_ready = 0; in_valid = 1; in_sel = 1;
        step();
        in_sel = 2;
        step();
        chk("t2_ready_low", in_ready, 0);
        chk("t2_hold", out_data, 8'hB2);
        in_sel = 3;
        step();
        chk("t2_hold2", out_data, 8'hB2);
        chk("t2_ready_low2", in_ready, 0);
        in_valid = 0; out_ready = 1;
        step();
        chk("t2_second", out_data, 8'hC3);
        chk("t2_second_v", out_valid, 1);
        step();
        chk("t2_drained", out_valid, 0);
        chk("t2_cnt", xfer_cnt, 6);

        // Test 4: simultaneous transfers in state ONE
        out_ready = 0; in_valid = 1; in_sel = 0;
        step();
        out_ready = 1; in_sel = 1;
        step();
        chk("t4_data1", out_data, 8'hB2);
        chk("t4_ready", in_ready, 1);
        in_sel = 2;
        step();
        chk("t4_data2", out_data, 8'hC3);
        chk("t4_valid", out_valid, 1);
        in_valid = 0;
        step();
        chk("t4_empty", out_valid, 0);

        // Test 5: reset while FULL
        out_ready = 0; in_valid = 1; in_sel = 3;
        step(); step();
        chk("t5_full", in_ready, 0);
        rst = 1; out_ready = 1;
        step();
        rst = 0; in_valid = 0;
        chk("t5_valid", out_valid, 0);
        chk("t5_ready", in_ready, 1);
        chk("t5_cnt", xfer_cnt, 0);
        step(); step();
        chk("t5_no_stale", out_valid, 0);
        chk("t5_cnt2", xfer_cnt, 0);

        // Test 3: out-of-range select on a 3-input instance
        in_data3 = {8'hC3, 8'hB2, 8'hA1};
        out_ready3 = 1; in_valid3 = 1; in_sel3 = 3;
        step();
        chk("t3_valid", out_valid3, 1);
        chk("t3_data", out_data3, 0);
        chk("t3_err", out_err3, 1);
        chk("t3_sel", out_sel3, 3);
        in_sel3 = 2;
        step();
        chk("t3_data_ok", out_data3, 8'hC3);
        chk("t3_err_ok", out_err3, 0);
        chk("t3_sel_ok", out_sel3, 2);
        in_valid3 = 0;
        step();
        chk("t3_empty", out_valid3, 0);
        chk("t3_cnt", xfer_cnt3, 2);
        trace = 0;

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            in_sel    = 2'($urandom);
            in_data   = $urandom;
            step();
        end
        rst = 0;

        // Test 6: counter wrap after 65537 transfers
        do_reset();
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 65537; i++) begin
            in_sel  = 2'($urandom);
            in_data = $urandom;
            step();
        end
        in_valid = 0;
        step();
        chk("t6_wrap", xfer_cnt, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nxw_skid.md
MUX_NXW_SKID -- requirements
Module: mux_nxw_skid

Interface
REQ-001 Parameter NUM_IN, default 4: number of input channels; legal range 2..16.
REQ-002 Parameter DATA_W, default 8: width of each channel and of the output; legal range 1..64.
REQ-003 Derived constant SEL_W = $clog2(NUM_IN), so 2 for the default.
REQ-004 Port clk  input  1: single clock, all logic on its rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port in_valid  input  1: upstream offers a beat.
REQ-007 Port in_ready  output  1: block can accept a beat; registered.
REQ-008 Port in_data  input  NUM_IN*DATA_W: packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 Port in_sel  input  SEL_W: channel select for the offered beat.
REQ-010 Port out_valid  output  1: output beat available.
REQ-011 Port out_ready  input  1: downstream accepts the beat.
REQ-012 Port out_data  output  DATA_W: selected channel data.
REQ-013 Port out_sel  output  SEL_W: select value carried alongside out_data.
REQ-014 Port out_err  output  1: beat was issued with an out-of-range select.
REQ-015 Port xfer_cnt  output  16: count of completed output transfers.

Function
REQ-016 An input transfer occurs on a rising edge when in_valid && in_ready.
REQ-017 An output transfer occurs on a rising edge when out_valid && out_ready.
REQ-018 On each input transfer, the block captures three items into its buffer together:
- in_data slice in_sel, or zero when in_sel >= NUM_IN;
- in_sel;
- err = (in_sel >= NUM_IN).
REQ-019 Latency: a beat accepted on edge N appears on out_* after edge N, provided the buffer was empty.
REQ-020 Buffer: a 2-entry FIFO (skid) with states EMPTY, ONE and FULL.
REQ-021 State transitions:
- EMPTY -> ONE on input transfer.
- ONE -> FULL on input transfer without output transfer.
- ONE -> EMPTY on output transfer without input transfer.
- ONE -> ONE on simultaneous input and output transfers.
- FULL -> ONE on output transfer.
REQ-022 in_ready = (state != FULL), driven from a register.
REQ-023 out_valid = (state != EMPTY).
REQ-024 Ordering is strictly FIFO; no beat is dropped or duplicated.
REQ-025 While out_valid=1 && out_ready=0, out_data, out_sel and out_err hold stable.
REQ-026 xfer_cnt increments by 1 on each output transfer and wraps from 16'hFFFF to 0.
REQ-027 The block ignores in_data and in_sel when in_valid=0.
REQ-028 With out_ready held high, sustained throughput is one beat per cycle.

Reset
REQ-029 While rst=1 at a clock edge, the block sets:
- state = EMPTY;
- in_ready = 1 on the following cycle;
- out_valid = 0;
- out_data, out_sel and out_err = 0;
- xfer_cnt = 0.
REQ-030 A reset asserted mid-operation discards all buffered beats, and no output transfer is counted on that edge.
REQ-031 The block accepts no input transfer on any edge where rst=1.

Structure
REQ-032 A shared package mux_pkg holds the buffer-state enum (EMPTY, ONE, FULL) and the constant XFER_CNT_W = 16.
REQ-033 The 2-entry buffer is implemented as one sub-module, skid_buf, parametrised by payload width (DATA_W + SEL_W + 1).
REQ-034 The top level contains the select and zero-fill logic, the skid_buf instance and the counter.

Verification
REQ-035 Test 1 (select mapping):
- Stimulus: defaults, in_data = {8'h44, 8'h33, 8'h22, 8'h11}, in_sel = 0..3 on back-to-back beats, out_ready = 1.
- Required response: out_data = 11, 22, 33, 44 on consecutive cycles; xfer_cnt = 4.
REQ-036 Test 2 (backpressure):
- Stimulus: out_ready = 0, three beats offered.
- Required response: two beats accepted; in_ready = 0 after the second; out_data holds the first beat.
- Stimulus: raise out_ready.
- Required response: both beats drain in order.
REQ-037 Test 3 (out-of-range select):
- Stimulus: NUM_IN = 3, in_sel = 3.
- Required response: out_data = 0, out_err = 1, out_sel = 3.
REQ-038 Test 4 (simultaneous transfers):
- Stimulus: buffer in state ONE, in and out transfers on the same edge.
- Required response: state stays ONE; order is preserved.
REQ-039 Test 5 (mid-operation reset):
- Stimulus: buffer FULL, rst = 1 for one cycle.
- Required response: out_valid = 0, in_ready = 1, xfer_cnt = 0; no stale beat emitted afterwards.
REQ-040 Test 6 (counter wrap):
- Stimulus: 65537 output transfers.
- Required response: xfer_cnt = 1.
